// File: rtl/fpu_norm_arbiter.sv
// Round-robin sharing of one combinational normalizer between the add/sub and mul/div pipes.
// Optional FPU_NRM_STATS_EN adds saturating overflow/underflow event counters.
module fpu_norm_arbiter #(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 28
`ifdef FPU_NRM_STATS_EN
   ,
   parameter int CNT_W  = 16
`endif
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [1:0]             i_req_valid,
   output logic [1:0]             o_req_ready,
   input  logic [1:0]             i_req_aos,
   input  logic [1:0]             i_req_c_alu,
   input  logic [1:0][EXP_W-1:0]  i_req_exp,
   input  logic [1:0][MANT_W-1:0] i_req_mant,
   output logic                   o_nrm_aos,
   output logic                   o_nrm_c_alu,
   output logic [EXP_W-1:0]       o_nrm_exp,
   output logic [MANT_W-1:0]      o_nrm_mant,
   input  logic [EXP_W-1:0]       i_nrm_exp,
   input  logic [MANT_W-1:0]      i_nrm_mant,
   input  logic                   i_nrm_ovf,
   input  logic                   i_nrm_unf,
   output logic [1:0]             o_rsp_valid,
   input  logic [1:0]             i_rsp_ready,
   output logic [1:0][EXP_W-1:0]  o_rsp_exp,
   output logic [1:0][MANT_W-1:0] o_rsp_mant,
   output logic [1:0]             o_rsp_ovf,
   output logic [1:0]             o_rsp_unf
`ifdef FPU_NRM_STATS_EN
   ,
   output logic [CNT_W-1:0]       o_ovf_cnt,
   output logic [CNT_W-1:0]       o_unf_cnt
`endif
);

   typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;

   buf_state_t state_q [2];
   buf_state_t state_d [2];
   logic [1:0] elig;
   logic [1:0] grant;
   logic       ptr_q;   // index of the last granted requester

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         elig[k] = i_req_valid[k] && ((state_q[k] == BUF_EMPTY) || i_rsp_ready[k]);
      end
      // On a tie the requester that did not win last time goes next.
      if (&elig) grant = ptr_q ? 2'b01 : 2'b10;
      else       grant = elig;
   end

   assign o_req_ready = grant;

   // NOTE: every output of a combinational block gets a default first; a missing else
   // would otherwise infer a latch.
   always_comb begin
      o_nrm_aos   = 1'b0;
      o_nrm_c_alu = 1'b0;
      o_nrm_exp   = '0;
      o_nrm_mant  = '0;
      for (int k = 0; k < 2; k++) begin
         if (grant[k]) begin
            o_nrm_aos   = i_req_aos[k];
            o_nrm_c_alu = i_req_c_alu[k];
            o_nrm_exp   = i_req_exp[k];
            o_nrm_mant  = i_req_mant[k];
         end
      end
   end

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         state_d[k] = state_q[k];
         unique case (state_q[k])
            BUF_EMPTY: if (grant[k]) state_d[k] = BUF_FULL;
            BUF_FULL:  if (!grant[k] && i_rsp_ready[k]) state_d[k] = BUF_EMPTY;
            default:   state_d[k] = BUF_EMPTY;
         endcase
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   // NOTE: result registers are reset too, because the response fields must read zero
   // after reset rather than whatever was buffered before.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= '{default: BUF_EMPTY};
         ptr_q      <= 1'b1;   // pretend requester 1 won last, so requester 0 takes the first tie
         o_rsp_exp  <= '0;
         o_rsp_mant <= '0;
         o_rsp_ovf  <= '0;
         o_rsp_unf  <= '0;
      end else begin
         state_q <= state_d;
         if (|grant) ptr_q <= grant[1];
         for (int k = 0; k < 2; k++) begin
            if (grant[k]) begin
               o_rsp_exp[k]  <= i_nrm_exp;
               o_rsp_mant[k] <= i_nrm_mant;
               o_rsp_ovf[k]  <= i_nrm_ovf;
               o_rsp_unf[k]  <= i_nrm_unf;
            end
         end
      end
   end

   always_comb begin
      for (int k = 0; k < 2; k++) o_rsp_valid[k] = (state_q[k] == BUF_FULL);
   end

`ifdef FPU_NRM_STATS_EN
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_ovf_cnt <= '0;
         o_unf_cnt <= '0;
      end else if (|grant) begin
         if (i_nrm_ovf && !(&o_ovf_cnt)) o_ovf_cnt <= o_ovf_cnt + 1'b1;
         if (i_nrm_unf && !(&o_unf_cnt)) o_unf_cnt <= o_unf_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fpu_norm_arbiter.sv
// Self-checking bench for fpu_norm_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model; includes a behavioural normalizer driving i_nrm_*.
module tb_fpu_norm_arbiter;
   localparam int EXP_W  = 8;
   localparam int MANT_W = 28;
   localparam int CNT_W  = 16;

   typedef struct packed {
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-1:0] mant;
      logic              ovf;
      logic              unf;
   } res_t;

   logic                   i_clk = 1'b0;
   logic                   i_rst_n = 1'b0;
   logic [1:0]             i_req_valid = '0;
   logic [1:0]             o_req_ready;
   logic [1:0]             i_req_aos = '0;
   logic [1:0]             i_req_c_alu = '0;
   logic [1:0][EXP_W-1:0]  i_req_exp = '0;
   logic [1:0][MANT_W-1:0] i_req_mant = '0;
   logic                   o_nrm_aos, o_nrm_c_alu;
   logic [EXP_W-1:0]       o_nrm_exp;
   logic [MANT_W-1:0]      o_nrm_mant;
   logic [EXP_W-1:0]       i_nrm_exp;
   logic [MANT_W-1:0]      i_nrm_mant;
   logic                   i_nrm_ovf, i_nrm_unf;
   logic [1:0]             o_rsp_valid;
   logic [1:0]             i_rsp_ready = '0;
   logic [1:0][EXP_W-1:0]  o_rsp_exp;
   logic [1:0][MANT_W-1:0] o_rsp_mant;
   logic [1:0]             o_rsp_ovf, o_rsp_unf;
`ifdef FPU_NRM_STATS_EN
   logic [CNT_W-1:0]       o_ovf_cnt, o_unf_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   fpu_norm_arbiter #(.EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_aos(i_req_aos), .i_req_c_alu(i_req_c_alu),
      .i_req_exp(i_req_exp), .i_req_mant(i_req_mant),
      .o_nrm_aos(o_nrm_aos), .o_nrm_c_alu(o_nrm_c_alu),
      .o_nrm_exp(o_nrm_exp), .o_nrm_mant(o_nrm_mant),
      .i_nrm_exp(i_nrm_exp), .i_nrm_mant(i_nrm_mant),
      .i_nrm_ovf(i_nrm_ovf), .i_nrm_unf(i_nrm_unf),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
      .o_rsp_exp(o_rsp_exp), .o_rsp_mant(o_rsp_mant),
      .o_rsp_ovf(o_rsp_ovf), .o_rsp_unf(o_rsp_unf)
`ifdef FPU_NRM_STATS_EN
      , .o_ovf_cnt(o_ovf_cnt), .o_unf_cnt(o_unf_cnt)
`endif
   );

   always #5 i_clk = ~i_clk;

   // Behavioural normalizer: right-shift case increments the exponent, left case shifts
   // the leading one to the MSB and subtracts the shift, clamping at the exponent limits.
   function automatic res_t norm_ref(input logic c_alu, input logic [EXP_W-1:0] exp,
                                     input logic [MANT_W-1:0] mant);
      res_t r;
      int   e;
      int   sh;
      bit   found;
      r = '0;
      if (c_alu) begin
         e      = int'(exp) + 1;
         r.mant = mant >> 1;
         if (e >= (1 << EXP_W) - 1) begin
            r.exp = '1;
            r.ovf = 1'b1;
         end else r.exp = e[EXP_W-1:0];
      end else begin
         sh    = 0;
         found = 1'b0;
         for (int i = MANT_W - 1; i >= 0; i--) begin
            if (!found && mant[i]) begin
               sh    = MANT_W - 1 - i;
               found = 1'b1;
            end
         end
         r.mant = mant << sh;
         e      = int'(exp) - sh;
         if (e < 0) begin
            r.exp = '0;
            r.unf = 1'b1;
         end else r.exp = e[EXP_W-1:0];
      end
      return r;
   endfunction

   res_t nrm_now;
   assign nrm_now    = norm_ref(o_nrm_c_alu, o_nrm_exp, o_nrm_mant);
   assign i_nrm_exp  = nrm_now.exp;
   assign i_nrm_mant = nrm_now.mant;
   assign i_nrm_ovf  = nrm_now.ovf;
   assign i_nrm_unf  = nrm_now.unf;

   // Transaction-level model of the arbiter.
   bit               m_full [2];
   res_t             m_data [2];
   int               m_last;
   logic [CNT_W-1:0] m_ovf, m_unf;

   function automatic int model_grant();
      bit e0, e1;
      e0 = i_req_valid[0] && (!m_full[0] || i_rsp_ready[0]);
      e1 = i_req_valid[1] && (!m_full[1] || i_rsp_ready[1]);
      if (e0 && e1) return 1 - m_last;
      if (e0) return 0;
      if (e1) return 1;
      return -1;
   endfunction

   // Advance the model with the current inputs, then cross one rising edge.
   task automatic tick();
      int g;
      if (!i_rst_n) begin
         m_full = '{0, 0};
         m_data = '{'0, '0};
         m_last = 1;
         m_ovf  = '0;
         m_unf  = '0;
      end else begin
         g = model_grant();
         for (int k = 0; k < 2; k++) begin
            if (g == k) begin
               m_full[k] = 1'b1;
               m_data[k] = norm_ref(i_req_c_alu[k], i_req_exp[k], i_req_mant[k]);
            end else if (i_rsp_ready[k]) m_full[k] = 1'b0;
         end
         if (g >= 0) begin
            m_last = g;
            if (m_data[g].ovf && m_ovf != '1) m_ovf = m_ovf + 1'b1;
            if (m_data[g].unf && m_unf != '1) m_unf = m_unf + 1'b1;
         end
      end
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst_n     = 1'b0;
      i_req_valid = '0;
      i_rsp_ready = '0;
      tick();
      tick();
      i_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      vectors++;
      if (o_rsp_valid !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_rsp_valid: got %b want 00", o_rsp_valid);
      end
      vectors++;
      if ({o_rsp_exp, o_rsp_mant, o_rsp_ovf, o_rsp_unf} !== '0) begin
         miscompares++;
         $display("FAIL reset_rsp_fields: got %h want 0", {o_rsp_exp, o_rsp_mant, o_rsp_ovf, o_rsp_unf});
      end
      vectors++;
      if ({o_req_ready, o_nrm_aos, o_nrm_c_alu, o_nrm_exp, o_nrm_mant} !== '0) begin
         miscompares++;
         $display("FAIL reset_idle_drive: got %h want 0", {o_req_ready, o_nrm_aos, o_nrm_c_alu, o_nrm_exp, o_nrm_mant});
      end
   endtask

   task automatic test_overflow();
      i_req_valid    = 2'b01;
      i_req_aos[0]   = 1'b0;
      i_req_c_alu[0] = 1'b1;
      i_req_exp[0]   = 8'hFE;
      i_req_mant[0]  = 28'h0000002;
      #1;
      vectors++;
      if (o_req_ready !== 2'b01) begin
         miscompares++;
         $display("FAIL ovf_ready: got %b want 01", o_req_ready);
      end
      vectors++;
      if ({o_nrm_c_alu, o_nrm_exp, o_nrm_mant} !== {1'b1, 8'hFE, 28'h0000002}) begin
         miscompares++;
         $display("FAIL ovf_nrm_drive: got %h want %h", {o_nrm_c_alu, o_nrm_exp, o_nrm_mant}, {1'b1, 8'hFE, 28'h0000002});
      end
      tick();
      i_req_valid = 2'b00;
      #1;
      vectors++;
      if ({o_rsp_valid[0], o_rsp_exp[0], o_rsp_mant[0], o_rsp_ovf[0], o_rsp_unf[0]} !==
          {1'b1, 8'hFF, 28'h0000001, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL ovf_rsp0: got %h want %h", {o_rsp_valid[0], o_rsp_exp[0], o_rsp_mant[0], o_rsp_ovf[0], o_rsp_unf[0]},
                  {1'b1, 8'hFF, 28'h0000001, 1'b1, 1'b0});
      end
      i_rsp_ready = 2'b01;
      tick();
      i_rsp_ready = 2'b00;
      vectors++;
      if (o_rsp_valid !== 2'b00) begin
         miscompares++;
         $display("FAIL ovf_drain: got %b want 00", o_rsp_valid);
      end
   endtask

   task automatic test_left_norm();
      i_req_valid    = 2'b10;
      i_req_aos[1]   = 1'b0;
      i_req_c_alu[1] = 1'b0;
      i_req_exp[1]   = 8'h80;
      i_req_mant[1]  = 28'h0800000;
      #1;
      vectors++;
      if (o_req_ready !== 2'b10) begin
         miscompares++;
         $display("FAIL lnorm_ready: got %b want 10", o_req_ready);
      end
      tick();
      i_req_valid = 2'b00;
      #1;
      vectors++;
      if ({o_rsp_valid[1], o_rsp_exp[1], o_rsp_mant[1], o_rsp_ovf[1], o_rsp_unf[1]} !==
          {1'b1, 8'h7C, 28'h8000000, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL lnorm_rsp1: got %h want %h", {o_rsp_valid[1], o_rsp_exp[1], o_rsp_mant[1], o_rsp_ovf[1], o_rsp_unf[1]},
                  {1'b1, 8'h7C, 28'h8000000, 1'b0, 1'b0});
      end
   endtask

   task automatic test_tie();
      logic [1:0] want;
      do_reset();
      i_req_valid = 2'b11;
      i_rsp_ready = 2'b11;
      for (int c = 0; c < 4; c++) begin
         i_req_exp  = {EXP_W'($urandom), EXP_W'($urandom)};
         i_req_mant = {MANT_W'($urandom), MANT_W'($urandom)};
         want = (c % 2 == 0) ? 2'b01 : 2'b10;
         #1;
         vectors++;
         if (o_req_ready !== want) begin
            miscompares++;
            $display("FAIL tie_grant%0d: got %b want %b", c, o_req_ready, want);
         end
         tick();
      end
      i_req_valid = 2'b00;
      i_rsp_ready = 2'b00;
   endtask

   task automatic test_backpressure();
      res_t held;
      do_reset();
      i_req_valid    = 2'b11;
      i_req_c_alu[0] = 1'b0;
      i_req_exp[0]   = 8'h40;
      i_req_mant[0]  = 28'h0012345;
      held = norm_ref(1'b0, 8'h40, 28'h0012345);
      #1;
      vectors++;
      if (o_req_ready !== 2'b01) begin
         miscompares++;
         $display("FAIL bp_first: got %b want 01", o_req_ready);
      end
      tick();
      i_rsp_ready = 2'b10;
      for (int c = 0; c < 4; c++) begin
         i_req_exp  = {EXP_W'($urandom), EXP_W'($urandom)};
         i_req_mant = {MANT_W'($urandom), MANT_W'($urandom)};
         #1;
         vectors++;
         if (o_req_ready !== 2'b10) begin
            miscompares++;
            $display("FAIL bp_grant1_%0d: got %b want 10", c, o_req_ready);
         end
         vectors++;
         if ({o_rsp_valid[0], o_rsp_exp[0], o_rsp_mant[0], o_rsp_ovf[0], o_rsp_unf[0]} !== {1'b1, held}) begin
            miscompares++;
            $display("FAIL bp_hold%0d: got %h want %h", c, {o_rsp_valid[0], o_rsp_exp[0], o_rsp_mant[0], o_rsp_ovf[0], o_rsp_unf[0]}, {1'b1, held});
         end
         tick();
      end
      i_rsp_ready = 2'b11;
      #1;
      vectors++;
      if (o_req_ready !== 2'b01) begin
         miscompares++;
         $display("FAIL bp_release: got %b want 01", o_req_ready);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      i_req_valid = 2'b11;
      i_rsp_ready = 2'b00;
      tick();
      vectors++;
      if (o_rsp_valid !== 2'b11) begin
         miscompares++;
         $display("FAIL mid_both_full: got %b want 11", o_rsp_valid);
      end
      i_rst_n = 1'b0;
      tick();
      vectors++;
      if ({o_rsp_valid, o_rsp_exp, o_rsp_mant, o_rsp_ovf, o_rsp_unf} !== '0) begin
         miscompares++;
         $display("FAIL mid_reset_clear: got %h want 0", {o_rsp_valid, o_rsp_exp, o_rsp_mant, o_rsp_ovf, o_rsp_unf});
      end
      i_rst_n = 1'b1;
      #1;
      vectors++;
      if (o_req_ready !== 2'b01) begin
         miscompares++;
         $display("FAIL mid_first_tie: got %b want 01", o_req_ready);
      end
      tick();
      i_req_valid = 2'b00;
   endtask

`ifdef FPU_NRM_STATS_EN
   task automatic test_stats();
      do_reset();
      i_req_valid    = 2'b01;
      i_rsp_ready    = 2'b01;
      i_req_c_alu[0] = 1'b1;
      i_req_exp[0]   = 8'hFE;
      i_req_mant[0]  = 28'h0000002;
      tick();
      tick();
      i_req_c_alu[0] = 1'b0;
      i_req_exp[0]   = 8'h05;
      i_req_mant[0]  = 28'h0100000;
      tick();
      i_req_valid = 2'b00;
      #1;
      vectors++;
      if (o_ovf_cnt !== 16'd2) begin
         miscompares++;
         $display("FAIL stats_ovf: got %0d want 2", o_ovf_cnt);
      end
      vectors++;
      if (o_unf_cnt !== 16'd1) begin
         miscompares++;
         $display("FAIL stats_unf: got %0d want 1", o_unf_cnt);
      end
   endtask
`endif

   task automatic test_random();
      int         g;
      logic [1:0] want_ready;
      logic [EXP_W+MANT_W+1:0] want_drive;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         i_rst_n     = ($urandom_range(0, 59) != 0);
         i_req_valid = 2'($urandom);
         i_rsp_ready = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b11 & 2'($urandom | $urandom);
         for (int k = 0; k < 2; k++) begin
            i_req_aos[k]   = 1'($urandom);
            i_req_c_alu[k] = 1'($urandom);
            case ($urandom_range(0, 3))
               0:       i_req_exp[k] = 8'hFE + 8'($urandom_range(0, 1));
               1:       i_req_exp[k] = 8'($urandom_range(0, 8));
               default: i_req_exp[k] = EXP_W'($urandom);
            endcase
            i_req_mant[k] = MANT_W'($urandom) >> $urandom_range(0, MANT_W - 1);
         end
         #1;
         g          = model_grant();
         want_ready = (g < 0) ? 2'b00 : (2'b01 << g);
         want_drive = (g < 0) ? '0 : {i_req_aos[g], i_req_c_alu[g], i_req_exp[g], i_req_mant[g]};
         vectors++;
         if (o_req_ready !== want_ready) begin
            miscompares++;
            $display("FAIL rnd_ready@%0d: got %b want %b", c, o_req_ready, want_ready);
         end
         vectors++;
         if ({o_nrm_aos, o_nrm_c_alu, o_nrm_exp, o_nrm_mant} !== want_drive) begin
            miscompares++;
            $display("FAIL rnd_drive@%0d: got %h want %h", c, {o_nrm_aos, o_nrm_c_alu, o_nrm_exp, o_nrm_mant}, want_drive);
         end
         vectors++;
         if (o_rsp_valid !== {m_full[1], m_full[0]}) begin
            miscompares++;
            $display("FAIL rnd_valid@%0d: got %b want %b", c, o_rsp_valid, {m_full[1], m_full[0]});
         end
         for (int k = 0; k < 2; k++) begin
            if (m_full[k]) begin
               vectors++;
               if ({o_rsp_exp[k], o_rsp_mant[k], o_rsp_ovf[k], o_rsp_unf[k]} !== m_data[k]) begin
                  miscompares++;
                  $display("FAIL rnd_rsp%0d@%0d: got %h want %h", k, c, {o_rsp_exp[k], o_rsp_mant[k], o_rsp_ovf[k], o_rsp_unf[k]}, m_data[k]);
               end
            end
         end
`ifdef FPU_NRM_STATS_EN
         vectors++;
         if ({o_ovf_cnt, o_unf_cnt} !== {m_ovf, m_unf}) begin
            miscompares++;
            $display("FAIL rnd_stats@%0d: got %h want %h", c, {o_ovf_cnt, o_unf_cnt}, {m_ovf, m_unf});
         end
`endif
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_overflow();
      test_left_norm();
      test_tie();
      test_backpressure();
      test_reset_mid();
`ifdef FPU_NRM_STATS_EN
      test_stats();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
